// File: rtl/vanilla_pkg.sv
// -----------------------------------------------------------------------------
// vanilla_pkg
//   Shared types and default widths for the WISHBONE initiator and the MMIO
//   device slots it talks to.
//   - WB_ADDR_W / WB_DATA_W / WB_TIMEOUT_CYC : default parameter values
//   - wb_init_state_t : initiator FSM states
//   - wb_cmd_t        : one host command (address, write data, direction)
// -----------------------------------------------------------------------------
package vanilla_pkg;

  localparam int WB_ADDR_W      = 5;
  localparam int WB_DATA_W      = 32;
  localparam int WB_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    RESP
  } wb_init_state_t;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] wdata;
    logic                 we;
  } wb_cmd_t;

endpackage

// File: rtl/wb_initiator_if.sv
// -----------------------------------------------------------------------------
// wb_initiator_if
//   Bundles the three interfaces of the WISHBONE initiator:
//   - command stream  : cmd_valid/cmd_ready, cmd_addr, cmd_wdata, cmd_we
//   - response stream : rsp_valid/rsp_ready, rsp_rdata, rsp_err
//   - WISHBONE bus    : ADR_O, DAT_O, DAT_I, CYC_O, STB_O, WE_O, ACK_I
//   modport master : the initiator's view
//   modport slave  : the environment's view (requester + bus slave)
// -----------------------------------------------------------------------------
interface wb_initiator_if
  import vanilla_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
);

  // command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_we;

  // response stream
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // WISHBONE
  logic [ADDR_W-1:0] ADR_O;
  logic [DATA_W-1:0] DAT_O;
  logic [DATA_W-1:0] DAT_I;
  logic              CYC_O;
  logic              STB_O;
  logic              WE_O;
  logic              ACK_I;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_we,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output ADR_O, DAT_O, CYC_O, STB_O, WE_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_we,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  ADR_O, DAT_O, CYC_O, STB_O, WE_O,
    output DAT_I, ACK_I
  );

endinterface

// File: rtl/wb_initiator.sv
// -----------------------------------------------------------------------------
// wb_initiator
//   Single-outstanding WISHBONE initiator. Each accepted command becomes one
//   classic bus cycle (one-cycle STB_O, CYC_O held until ACK_I); the result is
//   returned on a valid/ready response stream. One command in flight at most.
//
// Ports
//   CLK_I : clock, all logic on the rising edge
//   RST_I : synchronous, active-high reset
//   bus   : wb_initiator_if.master (command, response and WISHBONE signals)
//
// Parameters
//   ADDR_W, DATA_W : address / data widths (must match the interface instance)
//   TIMEOUT_CYC    : bus-cycle abort limit, only used with WB_TIMEOUT_EN
//
// Configuration
//   WB_TIMEOUT_EN : when defined, a bus cycle without ACK_I for TIMEOUT_CYC
//                   cycles is aborted and answered with rsp_err=1. When not
//                   defined the initiator waits for ACK_I forever and rsp_err
//                   is constant 0.
// -----------------------------------------------------------------------------
module wb_initiator
  import vanilla_pkg::*;
#(
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int DATA_W      = WB_DATA_W,
  parameter int TIMEOUT_CYC = WB_TIMEOUT_CYC
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  wb_initiator_if.master bus
);

  wb_init_state_t state_q, state_d;

  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              cyc_q;
  logic              stb_q;
  logic              we_q;
  logic              rsp_valid_q;

  logic in_bus;    // STROBE or WAIT: a bus cycle is open
  logic cmd_take;  // command handshake this cycle
  logic ack_take;  // slave acknowledge accepted this cycle
  logic tmo_hit;   // abort this cycle (never when ACK_I is present)

  assign in_bus   = (state_q == STROBE) || (state_q == WAIT);
  assign cmd_take = (state_q == IDLE) && bus.cmd_valid;
  assign ack_take = in_bus && bus.ACK_I;
  // Writes return zero; WE_O is still the value of the cycle being acked.
  assign rdata_d  = we_q ? '0 : bus.DAT_I;

  // ---------------------------------------------------------------------------
  // Optional bus-cycle timeout
  // ---------------------------------------------------------------------------
`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             rsp_err_q;

  // Counter holds the number of ACK-less cycles already spent; the cycle in
  // which it would reach TIMEOUT_CYC is the expiry cycle. ACK_I there wins.
  assign tmo_hit = in_bus && !bus.ACK_I &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tmo_cnt_q <= '0;
    end else if (cmd_take) begin
      tmo_cnt_q <= '0;
    end else if (in_bus && !bus.ACK_I) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rsp_err_q <= 1'b0;
    end else if (ack_take) begin
      rsp_err_q <= 1'b0;
    end else if (tmo_hit) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign bus.rsp_err = 1'b0;

  // Keeps the parameter referenced when the timeout is compiled out.
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge, so it sits inside the clocked
  // branch and is not in the sensitivity list.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.cmd_valid) state_d = STROBE;
      STROBE,
      WAIT:   if (bus.ACK_I || tmo_hit) state_d = RESP;
              else                      state_d = WAIT;
      RESP:   if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered bus and response outputs
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every register here sees the pre-edge
  // values of the others (e.g. rdata_d uses the old we_q).
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (cmd_take) begin
        adr_q <= bus.cmd_addr;
        dat_q <= bus.cmd_wdata;
        we_q  <= bus.cmd_we;
        cyc_q <= 1'b1;
        stb_q <= 1'b1;
      end

      // One strobe per transfer: slaves with side effects must see it once.
      if (state_q == STROBE) begin
        stb_q <= 1'b0;
      end

      if (ack_take) begin
        cyc_q       <= 1'b0;
        we_q        <= 1'b0;
        rdata_q     <= rdata_d;
        rsp_valid_q <= 1'b1;
      end else if (tmo_hit) begin
        cyc_q       <= 1'b0;
        rdata_q     <= '0;
        rsp_valid_q <= 1'b1;
      end

      if ((state_q == RESP) && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.ADR_O     = adr_q;
  assign bus.DAT_O     = dat_q;
  assign bus.WE_O      = we_q;
  assign bus.CYC_O     = cyc_q;
  assign bus.STB_O     = stb_q;

endmodule
